// File: rtl/turn_scheduler.sv
// turn_scheduler
//   Referee for a two-player turn-based throwing game (dog vs cat).
//   It alternates aim/flight phases between the players, applies hits to
//   hit points, enforces a per-phase timeout, and inserts a settle gap
//   between turns. The dog always opens a game.
//
// Parameters
//   TURN_TIMEOUT  cycles allowed in each aim phase and each flight phase
//   SETTLE_CYCLES dead time between turns, in cycles
//   HP_INIT       starting hit points per player (1..3)
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   start         pulse, begins a new game (honoured in IDLE and OVER only)
//   throw_enable  level from the active player; rising edge = throw released
//   throw_landed  single-cycle pulse, projectile finished
//   hit           qualifies throw_landed; 1 = opponent struck
//   dog_turn      dog owns the turn
//   cat_turn      cat owns the turn
//   turn_timeout  single-cycle pulse when an aim or flight phase times out
//   dog_hp        dog remaining hit points
//   cat_hp        cat remaining hit points
//   turn_count    completed turns, wraps 255 -> 0
//   game_over     game finished
//   winner_dog    1 = dog won (valid while game_over)
module turn_scheduler #(
    parameter int unsigned TURN_TIMEOUT  = 650000000,
    parameter int unsigned SETTLE_CYCLES = 65000000,
    parameter int unsigned HP_INIT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       throw_enable,
    input  logic       throw_landed,
    input  logic       hit,
    output logic       dog_turn,
    output logic       cat_turn,
    output logic       turn_timeout,
    output logic [1:0] dog_hp,
    output logic [1:0] cat_hp,
    output logic [7:0] turn_count,
    output logic       game_over,
    output logic       winner_dog
);

    localparam int unsigned TMAX = (TURN_TIMEOUT > SETTLE_CYCLES) ? TURN_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] PHASE_LAST  = TW'(TURN_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    HP_START    = 2'(HP_INIT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DOG_AIM    = 3'd1,
        DOG_FLIGHT = 3'd2,
        CAT_AIM    = 3'd3,
        CAT_FLIGHT = 3'd4,
        SETTLE     = 3'd5,
        OVER       = 3'd6
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          throw_prev;
    logic          throw_edge;
    logic          last_dog, last_dog_nx;  // who played the turn now settling
    logic [1:0]    dog_hp_nx, cat_hp_nx;
    logic [7:0]    turn_count_nx;
    logic          timeout_nx;
    logic          dog_turn_nx, cat_turn_nx, game_over_nx, winner_dog_nx;

    assign throw_edge = throw_enable & ~throw_prev;

    // State register; outputs are registered from next-state decode so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            throw_prev   <= 1'b0;
            last_dog     <= 1'b0;
            dog_hp       <= '0;
            cat_hp       <= '0;
            turn_count   <= '0;
            turn_timeout <= 1'b0;
            dog_turn     <= 1'b0;
            cat_turn     <= 1'b0;
            game_over    <= 1'b0;
            winner_dog   <= 1'b0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            throw_prev   <= throw_enable;
            last_dog     <= last_dog_nx;
            dog_hp       <= dog_hp_nx;
            cat_hp       <= cat_hp_nx;
            turn_count   <= turn_count_nx;
            turn_timeout <= timeout_nx;
            dog_turn     <= dog_turn_nx;
            cat_turn     <= cat_turn_nx;
            game_over    <= game_over_nx;
            winner_dog   <= winner_dog_nx;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_nx      = state;
        timer_nx      = timer;
        last_dog_nx   = last_dog;
        dog_hp_nx     = dog_hp;
        cat_hp_nx     = cat_hp;
        turn_count_nx = turn_count;
        timeout_nx    = 1'b0;

        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_nx      = DOG_AIM;
                    dog_hp_nx     = HP_START;
                    cat_hp_nx     = HP_START;
                    turn_count_nx = '0;
                    timer_nx      = '0;
                end
            end

            DOG_AIM, CAT_AIM: begin
                last_dog_nx = (state == DOG_AIM);
                if (throw_edge) begin
                    // a throw edge beats a coincident timeout
                    state_nx = (state == DOG_AIM) ? DOG_FLIGHT : CAT_FLIGHT;
                    timer_nx = '0;
                end else if (timer == PHASE_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = SETTLE;
                    timer_nx   = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            DOG_FLIGHT: begin
                last_dog_nx = 1'b1;
                if (throw_landed) begin
                    if (hit && cat_hp != 2'd0) cat_hp_nx = cat_hp - 2'd1;
                    state_nx = (cat_hp_nx == 2'd0) ? OVER : SETTLE;
                    timer_nx = '0;
                end else if (timer == PHASE_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = SETTLE;
                    timer_nx   = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            CAT_FLIGHT: begin
                last_dog_nx = 1'b0;
                if (throw_landed) begin
                    if (hit && dog_hp != 2'd0) dog_hp_nx = dog_hp - 2'd1;
                    state_nx = (dog_hp_nx == 2'd0) ? OVER : SETTLE;
                    timer_nx = '0;
                end else if (timer == PHASE_LAST) begin
                    timeout_nx = 1'b1;
                    state_nx   = SETTLE;
                    timer_nx   = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_nx      = last_dog ? CAT_AIM : DOG_AIM;
                    turn_count_nx = turn_count + 8'd1;
                    timer_nx      = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // Output decode from the next state
    always_comb begin
        dog_turn_nx   = (state_nx == DOG_AIM) || (state_nx == DOG_FLIGHT);
        cat_turn_nx   = (state_nx == CAT_AIM) || (state_nx == CAT_FLIGHT);
        game_over_nx  = (state_nx == OVER);
        winner_dog_nx = (state_nx == OVER) && (cat_hp_nx == 2'd0);
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler
//   Directed bench for turn_scheduler with TURN_TIMEOUT=8, SETTLE_CYCLES=4,
//   HP_INIT=2. Inputs change 1 ns after a rising edge; outputs are checked
//   at that same point, i.e. after the edge has settled.
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       throw_enable = 1'b0;
    logic       throw_landed = 1'b0;
    logic       hit = 1'b0;
    logic       dog_turn, cat_turn, turn_timeout, game_over, winner_dog;
    logic [1:0] dog_hp, cat_hp;
    logic [7:0] turn_count;

    int vectors = 0;
    int miscompares = 0;

    turn_scheduler #(
        .TURN_TIMEOUT (8),
        .SETTLE_CYCLES(4),
        .HP_INIT      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .throw_enable(throw_enable),
        .throw_landed(throw_landed),
        .hit         (hit),
        .dog_turn    (dog_turn),
        .cat_turn    (cat_turn),
        .turn_timeout(turn_timeout),
        .dog_hp      (dog_hp),
        .cat_hp      (cat_hp),
        .turn_count  (turn_count),
        .game_over   (game_over),
        .winner_dog  (winner_dog)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dog_turn"}, int'(dog_turn), 0);
        chk({tag, ".cat_turn"}, int'(cat_turn), 0);
        chk({tag, ".timeout"}, int'(turn_timeout), 0);
        chk({tag, ".dog_hp"}, int'(dog_hp), 0);
        chk({tag, ".cat_hp"}, int'(cat_hp), 0);
        chk({tag, ".turn_count"}, int'(turn_count), 0);
        chk({tag, ".game_over"}, int'(game_over), 0);
        chk({tag, ".winner_dog"}, int'(winner_dog), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        tick();
        chk_all_zero("idle_after_rst");

        // Game start: dog aims, hp loaded
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.dog_turn", int'(dog_turn), 1);
        chk("start.cat_turn", int'(cat_turn), 0);
        chk("start.dog_hp", int'(dog_hp), 2);
        chk("start.cat_hp", int'(cat_hp), 2);
        chk("start.turn_count", int'(turn_count), 0);

        // Dog throws and hits
        throw_enable = 1'b1;
        tick();
        chk("dog_flight.dog_turn", int'(dog_turn), 1);
        throw_landed = 1'b1;
        hit = 1'b1;
        tick();
        throw_landed = 1'b0;
        hit = 1'b0;
        throw_enable = 1'b0;
        chk("dog_hit.cat_hp", int'(cat_hp), 1);
        chk("settle1.dog_turn", int'(dog_turn), 0);
        chk("settle1.cat_turn", int'(cat_turn), 0);
        // stray landed+hit during settle must not touch hp
        throw_landed = 1'b1;
        hit = 1'b1;
        tick();
        throw_landed = 1'b0;
        hit = 1'b0;
        chk("settle2.turns", int'({dog_turn, cat_turn}), 0);
        chk("stray_land.cat_hp", int'(cat_hp), 1);
        chk("stray_land.dog_hp", int'(dog_hp), 2);
        tick();
        chk("settle3.turns", int'({dog_turn, cat_turn}), 0);
        tick();
        chk("settle4.turns", int'({dog_turn, cat_turn}), 0);
        chk("settle4.turn_count", int'(turn_count), 0);
        tick();
        chk("cat_aim.cat_turn", int'(cat_turn), 1);
        chk("cat_aim.dog_turn", int'(dog_turn), 0);
        chk("cat_aim.turn_count", int'(turn_count), 1);

        // Cat throws and misses
        throw_enable = 1'b1;
        tick();
        chk("cat_flight.cat_turn", int'(cat_turn), 1);
        throw_landed = 1'b1;
        hit = 1'b0;
        tick();
        throw_landed = 1'b0;
        throw_enable = 1'b0;
        chk("cat_miss.dog_hp", int'(dog_hp), 2);
        chk("cat_miss.turns", int'({dog_turn, cat_turn}), 0);
        tick();
        tick();
        tick();
        chk("settle_b4.turns", int'({dog_turn, cat_turn}), 0);
        tick();
        chk("dog_aim2.dog_turn", int'(dog_turn), 1);
        chk("dog_aim2.turn_count", int'(turn_count), 2);

        // Let the aim timer reach 7, then throw in that very cycle
        for (int i = 0; i < 7; i++) tick();
        chk("aim_t7.dog_turn", int'(dog_turn), 1);
        chk("aim_t7.timeout", int'(turn_timeout), 0);
        throw_enable = 1'b1;
        tick();
        chk("edge_at_t7.timeout", int'(turn_timeout), 0);
        chk("edge_at_t7.dog_turn", int'(dog_turn), 1);

        // Second dog hit ends the game
        throw_landed = 1'b1;
        hit = 1'b1;
        tick();
        throw_landed = 1'b0;
        hit = 1'b0;
        throw_enable = 1'b0;
        chk("over.game_over", int'(game_over), 1);
        chk("over.winner_dog", int'(winner_dog), 1);
        chk("over.cat_hp", int'(cat_hp), 0);
        chk("over.dog_hp", int'(dog_hp), 2);
        chk("over.turns", int'({dog_turn, cat_turn}), 0);
        tick();
        tick();
        chk("over_hold.game_over", int'(game_over), 1);
        chk("over_hold.turn_count", int'(turn_count), 2);

        // Restart from OVER
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.dog_turn", int'(dog_turn), 1);
        chk("restart.game_over", int'(game_over), 0);
        chk("restart.winner_dog", int'(winner_dog), 0);
        chk("restart.hp", int'({dog_hp, cat_hp}), 'b1010);
        chk("restart.turn_count", int'(turn_count), 0);

        // Aim timeout: 8 idle cycles in DOG_AIM
        for (int i = 0; i < 7; i++) tick();
        chk("aim_to_t7.timeout", int'(turn_timeout), 0);
        tick();
        chk("aim_to.timeout", int'(turn_timeout), 1);
        chk("aim_to.dog_turn", int'(dog_turn), 0);
        tick();
        chk("aim_to.pulse_width", int'(turn_timeout), 0);
        tick();
        tick();
        tick();
        chk("aim_to.cat_turn", int'(cat_turn), 1);
        chk("aim_to.hp", int'({dog_hp, cat_hp}), 'b1010);
        chk("aim_to.turn_count", int'(turn_count), 1);

        // start ignored mid-game, then async reset in CAT_FLIGHT
        throw_enable = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored.cat_turn", int'(cat_turn), 1);
        chk("start_ignored.dog_turn", int'(dog_turn), 0);
        chk("start_ignored.turn_count", int'(turn_count), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        throw_enable = 1'b0;
        tick();
        tick();
        chk_all_zero("idle_after_rst2");

        // Flight timeout counts as a miss
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start2.dog_turn", int'(dog_turn), 1);
        throw_enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("flight_t7.timeout", int'(turn_timeout), 0);
        chk("flight_t7.dog_turn", int'(dog_turn), 1);
        tick();
        chk("flight_to.timeout", int'(turn_timeout), 1);
        chk("flight_to.cat_hp", int'(cat_hp), 2);
        chk("flight_to.turns", int'({dog_turn, cat_turn}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter TURN_TIMEOUT, default 650000000, meaning cycles allowed per aim phase and per flight phase (10 s at 65 MHz).
REQ-002 Parameter SETTLE_CYCLES, default 65000000, meaning dead time between turns (1 s).
REQ-003 Parameter HP_INIT, default 3, meaning starting hit points per player (1..3).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  pulse; begins a new game.
REQ-008 throw_enable  input  1  level from the active player's turn FSM; rising edge means a throw was released.
REQ-009 throw_landed  input  1  single-cycle pulse; projectile finished.
REQ-010 hit  input  1  qualifies throw_landed; 1 means the opponent was struck.
REQ-011 dog_turn  output  1  dog owns the turn.
REQ-012 cat_turn  output  1  cat owns the turn.
REQ-013 turn_timeout  output  1  single-cycle pulse when a phase times out.
REQ-014 dog_hp, cat_hp  output  2 each  remaining hit points.
REQ-015 turn_count  output  8  completed turns.
REQ-016 game_over  output  1  game finished; winner_dog  output  1  1 means dog won (valid while game_over).

Function
REQ-017 States: IDLE, DOG_AIM, DOG_FLIGHT, CAT_AIM, CAT_FLIGHT, SETTLE, OVER; all outputs registered.
REQ-018 IDLE: turn outputs 0; start -> DOG_AIM; dog_hp and cat_hp load HP_INIT, turn_count loads 0, phase timer clears.
REQ-019 X_AIM (X = DOG/CAT): X_turn=1, other turn=0; timer increments each cycle.
REQ-020 X_AIM: rising edge of throw_enable (registered previous-value detect) -> X_FLIGHT, timer clears.
REQ-021 X_AIM: timer reaches TURN_TIMEOUT-1 with no throw edge -> turn_timeout=1 for one cycle, -> SETTLE; a throw edge in the same cycle wins, no timeout.
REQ-022 X_FLIGHT: X_turn stays 1; timer increments; throw_landed with hit=1 decrements the opponent's hp (saturating at 0); throw_landed with hit=0 leaves hp unchanged.
REQ-023 X_FLIGHT: on throw_landed, opponent hp reaching 0 -> OVER; otherwise -> SETTLE.
REQ-024 X_FLIGHT: timer reaches TURN_TIMEOUT-1 without throw_landed -> turn_timeout pulse, treated as miss, -> SETTLE.
REQ-025 SETTLE: both turn outputs 0; counts SETTLE_CYCLES cycles, then enters the AIM state of the player opposite the one who just played; turn_count increments by 1 on that exit, wrapping 255 -> 0.
REQ-026 OVER: game_over=1, winner_dog = (cat_hp==0), turn outputs 0, hp frozen; start -> re-initialise exactly as in IDLE and go to DOG_AIM.
REQ-027 start is ignored in all states except IDLE and OVER.
REQ-028 throw_landed and hit are ignored outside FLIGHT states; hit without throw_landed is ignored.
REQ-029 dog_turn and cat_turn SHALL never both be 1.
REQ-030 Illegal state encoding -> IDLE on next clock.

Reset
REQ-031 rst asserted at any time, including mid-flight or mid-settle, SHALL immediately force state=IDLE, dog_turn=0, cat_turn=0, turn_timeout=0, dog_hp=0, cat_hp=0, turn_count=0, game_over=0, winner_dog=0, timers=0, edge-detect register=0.
REQ-032 After rst deasserts, the block stays in IDLE until start.

Verification (TURN_TIMEOUT=8, SETTLE_CYCLES=4, HP_INIT=2)
REQ-033 start pulse -> next cycle dog_turn=1, dog_hp=2, cat_hp=2, turn_count=0.
REQ-034 Dog throw edge, then throw_landed+hit -> cat_hp=1, both turns 0 for 4 cycles, then cat_turn=1, turn_count=1.
REQ-035 No throw for 8 cycles in DOG_AIM -> turn_timeout pulse on 8th cycle, SETTLE, then cat_turn=1, hp unchanged.
REQ-036 Two dog hits separated by a cat miss -> game_over=1, winner_dog=1, cat_hp=0, turn outputs 0; later start -> dog_turn=1, hp=2/2.
REQ-037 Throw edge coincident with timer=7 in AIM -> FLIGHT, no turn_timeout; stray throw_landed during SETTLE -> no hp change.
REQ-038 rst asserted during CAT_FLIGHT -> all outputs 0 within the same cycle (asynchronous), IDLE after release, start ignored mid-game is checked with no state change.
